// File: rtl/nes_joypad_port_if.sv
// NES controller-port bus: strobe/clock from the core,
// serial data and read counts back to it.
interface nes_joypad_port_if;
  logic       strobe;
  logic [1:0] joy_clk;
  logic [1:0] joy_data;
  logic [9:0] rd_count;

  modport master (
    output strobe,
    output joy_clk,
    input  joy_data,
    input  rd_count
  );

  modport slave (
    input  strobe,
    input  joy_clk,
    output joy_data,
    output rd_count
  );
endinterface

// File: rtl/nes_joypad_port.sv
// Two-port NES joypad serializer, standard or Four Score,
// with per-pad turbo A/B driven by a shared autofire phase.
module nes_joypad_port #(
    parameter int         AUTOFIRE_DIV = 1253000,
    parameter logic       FILL_BIT     = 1'b1,
    parameter logic [7:0] SIG_P0       = 8'h10,
    parameter logic [7:0] SIG_P1       = 8'h20
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [31:0]  btn,
    input  logic [7:0]   turbo,
    input  logic         fourscore_en,
    nes_joypad_port_if.slave bus
);

    localparam int CW = $clog2(AUTOFIRE_DIV);
    localparam logic [CW-1:0] AF_LAST = CW'(AUTOFIRE_DIV - 1);
    localparam logic [4:0] FRAME_LEN = 5'd24;

    logic [CW-1:0] af_cnt;
    logic          phase;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            af_cnt <= '0;
            phase  <= 1'b0;
        end else if (af_cnt == AF_LAST) begin
            af_cnt <= '0;
            phase  <= ~phase;
        end else begin
            af_cnt <= af_cnt + 1'b1;
        end
    end

    logic [7:0] eff [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            eff[n] = btn[8*n +: 8] |
                     {6'b0,
                      turbo[2*n+1] & phase,
                      turbo[2*n] & phase};
        end
    end

    logic [23:0] load_val [2];

    always_comb begin
        load_val[0] = {{16{FILL_BIT}}, eff[0]};
        load_val[1] = {{16{FILL_BIT}}, eff[1]};
        if (fourscore_en) begin
            load_val[0] = {SIG_P0, eff[2], eff[0]};
            load_val[1] = {SIG_P1, eff[3], eff[1]};
        end
    end

    logic [23:0] sreg [2];
    logic [4:0]  cnt  [2];
    logic [1:0]  prev_clk;
    logic [1:0]  rd_edge;

    assign rd_edge = prev_clk & ~bus.joy_clk;

    // A strobe cycle always wins over a coincident read edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prev_clk <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                sreg[p] <= {24{FILL_BIT}};
                cnt[p]  <= 5'd0;
            end
        end else begin
            prev_clk <= bus.joy_clk;
            for (int p = 0; p < 2; p++) begin
                if (bus.strobe) begin
                    sreg[p] <= load_val[p];
                    cnt[p]  <= 5'd0;
                end else if (rd_edge[p]) begin
                    sreg[p] <= {FILL_BIT, sreg[p][23:1]};
                    if (cnt[p] != FRAME_LEN)
                        cnt[p] <= cnt[p] + 5'd1;
                end
            end
        end
    end

    assign bus.joy_data = {sreg[1][0], sreg[0][0]};
    assign bus.rd_count = {cnt[1], cnt[0]};

endmodule

// File: tb/tb_nes_joypad_port.sv
// Bench for nes_joypad_port: frame-level model plus
// hand-computed literal checks and random traffic.
module tb_nes_joypad_port;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic [31:0] btn = '0;
    logic [7:0]  turbo = '0;
    logic        fs = 1'b0;
    logic        chk_on = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    nes_joypad_port_if bus ();

    nes_joypad_port #(
        .AUTOFIRE_DIV(DIV),
        .FILL_BIT(1'b1),
        .SIG_P0(8'h10),
        .SIG_P1(8'h20)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .btn(btn),
        .turbo(turbo),
        .fourscore_en(fs),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: each port holds its 24-bit frame and a read index.
    logic [23:0] m_frame [2] = '{24'hFFFFFF, 24'hFFFFFF};
    int          m_reads [2] = '{0, 0};
    logic [1:0]  m_prev = 2'b00;
    int          m_edges = 0;

    function automatic logic [7:0] pad(input int n,
                                       input logic ph);
        logic [7:0] v;
        v = btn[8*n +: 8];
        if (ph && turbo[2*n])   v[0] = 1'b1;
        if (ph && turbo[2*n+1]) v[1] = 1'b1;
        return v;
    endfunction

    function automatic logic [23:0] frame_of(input int p,
                                             input logic ph);
        logic [7:0] sig;
        sig = (p == 0) ? 8'h10 : 8'h20;
        if (fs) return {sig, pad(p + 2, ph), pad(p, ph)};
        return {16'hFFFF, pad(p, ph)};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_edges = 0;
            m_prev  = 2'b00;
            for (int p = 0; p < 2; p++) begin
                m_frame[p] = 24'hFFFFFF;
                m_reads[p] = 0;
            end
        end else begin
            logic ph;
            ph = ((m_edges / DIV) % 2) == 1;
            for (int p = 0; p < 2; p++) begin
                if (bus.strobe) begin
                    m_frame[p] = frame_of(p, ph);
                    m_reads[p] = 0;
                end else if (m_prev[p] && !bus.joy_clk[p]) begin
                    if (m_reads[p] < 24) m_reads[p]++;
                end
            end
            m_prev = bus.joy_clk;
            m_edges++;
        end
    end

    function automatic logic [1:0] exp_data();
        logic [1:0] d;
        for (int p = 0; p < 2; p++)
            d[p] = (m_reads[p] < 24) ?
                   m_frame[p][m_reads[p]] : 1'b1;
        return d;
    endfunction

    function automatic logic [9:0] exp_rc();
        return {5'(m_reads[1]), 5'(m_reads[0])};
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            chk("joy_data", 32'(bus.joy_data), 32'(exp_data()));
            chk("rd_count", 32'(bus.rd_count), 32'(exp_rc()));
        end
    end

    task automatic strobe_pulse();
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk) bus.strobe = 1'b0;
    endtask

    task automatic rd(input logic [1:0] m,
                      output logic [1:0] d,
                      output logic [9:0] rc);
        @(negedge clk) bus.joy_clk = m;
        @(negedge clk);
        d  = bus.joy_data;
        rc = bus.rd_count;
        bus.joy_clk = 2'b00;
    endtask

    initial begin
        logic [1:0]  d;
        logic [9:0]  rc;
        logic [25:0] w0, w1;
        logic [11:0] af;

        bus.strobe  = 1'b0;
        bus.joy_clk = 2'b00;
        #1 resetn = 1'b0;
        chk_on = 1'b1;
        @(negedge clk) resetn = 1'b1;
        chk("reset_data", 32'(bus.joy_data), 32'h3);
        chk("reset_rc", 32'(bus.rd_count), 32'h0);

        // Standard mode, pad0 = 1000_0101
        btn = 32'h0000_0085;
        strobe_pulse();
        w0 = '0;
        for (int i = 0; i < 26; i++) begin
            rd(2'b01, d, rc);
            w0[i] = d[0];
            if (i == 23) chk("std_rc23", 32'(rc[4:0]), 32'd23);
        end
        chk("std_seq", 32'(w0[9:0]), 32'b11_1000_0101);
        @(negedge clk);
        chk("std_rc_sat", 32'(bus.rd_count[4:0]), 32'd24);

        // Four Score
        btn = {8'h00, 8'h80, 8'h02, 8'h01};
        fs = 1'b1;
        strobe_pulse();
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 26; i++) begin
            rd(2'b11, d, rc);
            w0[i] = d[0];
            w1[i] = d[1];
        end
        chk("fs_p0", 32'(w0[23:0]), 32'h108001);
        chk("fs_p1", 32'(w1[23:0]), 32'h200002);
        chk("fs_fill", 32'({w1[25:24], w0[25:24]}), 32'hF);

        // Strobe held: data follows A, edges ignored
        btn = '0;
        fs = 1'b0;
        @(negedge clk) bus.strobe = 1'b1;
        @(negedge clk);
        chk("hold_a0", 32'(bus.joy_data[0]), 32'd0);
        btn[0] = 1'b1;
        @(negedge clk);
        chk("hold_a1", 32'(bus.joy_data[0]), 32'd1);
        bus.joy_clk = 2'b01;
        @(negedge clk) bus.joy_clk = 2'b00;
        @(negedge clk);
        @(negedge clk);
        chk("hold_rc", 32'(bus.rd_count[4:0]), 32'd0);
        bus.strobe = 1'b0;

        // Strobe and read edge in the same cycle
        for (int i = 0; i < 3; i++) rd(2'b01, d, rc);
        @(negedge clk) bus.joy_clk = 2'b01;
        @(negedge clk) begin
            bus.strobe  = 1'b1;
            bus.joy_clk = 2'b00;
        end
        @(negedge clk) bus.strobe = 1'b0;
        chk("same_rc", 32'(bus.rd_count[4:0]), 32'd0);
        chk("same_data", 32'(bus.joy_data[0]), 32'd1);

        // Async reset mid-frame in Four Score mode
        fs = 1'b1;
        btn = 32'h0000_0000;
        strobe_pulse();
        for (int i = 0; i < 5; i++) rd(2'b11, d, rc);
        @(negedge clk) #1 resetn = 1'b0;
        #1;
        chk("arst_data", 32'(bus.joy_data), 32'h3);
        chk("arst_rc", 32'(bus.rd_count), 32'h0);
        @(negedge clk) resetn = 1'b1;

        // Autofire: phase toggles every DIV clocks from reset
        fs = 1'b0;
        @(negedge clk) #1 resetn = 1'b0;
        @(negedge clk) begin
            resetn = 1'b1;
            btn = '0;
            turbo = 8'h01;
            bus.strobe = 1'b1;
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            af[i] = bus.joy_data[0];
        end
        bus.strobe = 1'b0;
        turbo = '0;
        chk("autofire", 32'(af), 32'(12'b0000_1111_0000));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom % 50 == 0) btn = $urandom;
            if ($urandom % 97 == 0) turbo = 8'($urandom);
            if ($urandom % 40 == 0) fs = 1'($urandom);
            bus.strobe  = ($urandom % 20 == 0);
            bus.joy_clk = 2'($urandom);
        end
        @(negedge clk) begin
            bus.strobe  = 1'b0;
            bus.joy_clk = 2'b00;
        end
        @(negedge clk);
        chk_on = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
